// File: rtl/branch_resolve_unit_if.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit_if
//   Bundles the decode-side handshake, the operand read/valid handshake and
//   the redirect result of branch_resolve_unit.
//
//   master : decode / register-file side (offers instructions and operands)
//   slave  : branch_resolve_unit
//
//   instr_valid/instr_ready  instruction handshake, br_op one-hot opcode
//   pc, imm                  PC and sign-extended immediate of the offer
//   rs1_read/rs2_read        operand requests while waiting
//   rs1_valid/rs2_valid      operand qualifiers, rs1_value/rs2_value data
//   done, pc_j_valid         one-cycle result pulse and taken redirect
//   next_pc, link_value      resolved PC and return address
//   link_valid, misaligned   write-back enable and misalignment flag
//   timeout                  one-cycle abort pulse
//   is_compressed            only with BRANCH_RVC_EN defined
// ---------------------------------------------------------------------------
interface branch_resolve_unit_if #(
    parameter int XLEN = 32
);
    logic            instr_valid;
    logic            instr_ready;
    logic [7:0]      br_op;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
`ifdef BRANCH_RVC_EN
    logic            is_compressed;
`endif
    logic            rs1_read;
    logic            rs2_read;
    logic            rs1_valid;
    logic            rs2_valid;
    logic [XLEN-1:0] rs1_value;
    logic [XLEN-1:0] rs2_value;
    logic            done;
    logic            pc_j_valid;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] link_value;
    logic            link_valid;
    logic            misaligned;
    logic            timeout;

    modport master (
`ifdef BRANCH_RVC_EN
        output is_compressed,
`endif
        output instr_valid, br_op, pc, imm,
        output rs1_valid, rs2_valid, rs1_value, rs2_value,
        input  instr_ready, rs1_read, rs2_read,
        input  done, pc_j_valid, next_pc, link_value, link_valid,
        input  misaligned, timeout
    );

    modport slave (
`ifdef BRANCH_RVC_EN
        input  is_compressed,
`endif
        input  instr_valid, br_op, pc, imm,
        input  rs1_valid, rs2_valid, rs1_value, rs2_value,
        output instr_ready, rs1_read, rs2_read,
        output done, pc_j_valid, next_pc, link_value, link_valid,
        output misaligned, timeout
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
//   Resolves one decoded branch/jump at a time between decode and the fetch
//   PC mux. Flow: IDLE (accept) -> WAIT (fetch operands, bounded) ->
//   RESOLVE (compare, form targets) -> IDLE with a one-cycle done pulse.
//
// Parameters
//   XLEN          datapath, PC and immediate width
//   WAIT_TIMEOUT  WAIT cycles before the operand fetch is abandoned (>=1)
//   TCNT_W        wait counter width, must hold WAIT_TIMEOUT
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   bus           branch_resolve_unit_if.slave (handshakes and results)
//
// Optional feature macro: BRANCH_RVC_EN
//   Adds bus.is_compressed: fall-through/link become pc+2 and only
//   target[0] counts as misaligned.
// ---------------------------------------------------------------------------
module branch_resolve_unit #(
    parameter int XLEN         = 32,
    parameter int WAIT_TIMEOUT = 16,
    parameter int TCNT_W       = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_resolve_unit_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RESOLVE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [TCNT_W-1:0]   cnt;
    logic [TCNT_W-1:0]   cnt_next;
    logic                accept;
    logic                capture;
    logic                tmo;

    logic [7:0]          op_p0;
    logic [XLEN-1:0]     pc_p0;
    logic [XLEN-1:0]     imm_p0;
`ifdef BRANCH_RVC_EN
    logic                rvc_p0;
`endif
    logic signed [XLEN-1:0] rs1_p1;
    logic signed [XLEN-1:0] rs2_p1;

    logic                need_rs1;
    logic                need_rs2;
    logic                operands_ok;
    logic                is_jump;
    logic                taken;
    logic                mis;
    logic [XLEN-1:0]     step;
    logic [XLEN-1:0]     target;
    logic [XLEN-1:0]     fall_through;

    // Condition evaluation for the six conditional branches (op bits 0..5).
    function automatic logic branch_taken(
        input logic [5:0]             op,
        input logic signed [XLEN-1:0] a,
        input logic signed [XLEN-1:0] b
    );
        logic eq;
        logic lt;
        logic ltu;
        eq  = (a == b);
        lt  = (a < b);
        ltu = ($unsigned(a) < $unsigned(b));
        return (op[0] & eq)  | (op[1] & ~eq) |
               (op[2] & lt)  | (op[3] & ~lt) |
               (op[4] & ltu) | (op[5] & ~ltu);
    endfunction

    // JAL (bit 6) needs no operand; JALR (bit 7) only rs1.
    assign need_rs1    = (|op_p0[5:0]) | op_p0[7];
    assign need_rs2    = |op_p0[5:0];
    assign operands_ok = (~need_rs1 | bus.rs1_valid) & (~need_rs2 | bus.rs2_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        accept          = 1'b0;
        capture         = 1'b0;
        tmo             = 1'b0;
        bus.instr_ready = 1'b0;
        bus.rs1_read    = 1'b0;
        bus.rs2_read    = 1'b0;
        case (state)
            S_IDLE: begin
                bus.instr_ready = 1'b1;
                if (bus.instr_valid && $onehot(bus.br_op)) begin
                    accept     = 1'b1;
                    cnt_next   = '0;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                bus.rs1_read = need_rs1;
                bus.rs2_read = need_rs2;
                if (operands_ok) begin
                    capture    = 1'b1;
                    state_next = S_RESOLVE;
                end else if (cnt + TCNT_W'(1) == TCNT_W'(WAIT_TIMEOUT)) begin
                    tmo        = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    cnt_next = cnt + TCNT_W'(1);
                end
            end
            S_RESOLVE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ---- stage p0: instruction capture at accept ----
    always_ff @(posedge clk) begin
        if (rst) begin
            op_p0  <= '0;
`ifdef BRANCH_RVC_EN
            rvc_p0 <= 1'b0;
`endif
        end else if (accept) begin
            op_p0  <= bus.br_op;
`ifdef BRANCH_RVC_EN
            rvc_p0 <= bus.is_compressed;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            pc_p0  <= bus.pc;
            imm_p0 <= bus.imm;
        end
    end

    // ---- stage p1: operand capture leaving WAIT ----
    always_ff @(posedge clk) begin
        if (capture) begin
            rs1_p1 <= bus.rs1_value;
            rs2_p1 <= bus.rs2_value;
        end
    end

    // ---- stage p2: resolve and register the redirect ----
    assign is_jump = op_p0[6] | op_p0[7];
    assign taken   = is_jump | branch_taken(op_p0[5:0], rs1_p1, rs2_p1);
    assign target  = op_p0[7] ? (($unsigned(rs1_p1) + imm_p0) & ~XLEN'(1))
                              : (pc_p0 + imm_p0);
`ifdef BRANCH_RVC_EN
    assign step    = rvc_p0 ? XLEN'(2) : XLEN'(4);
    assign mis     = taken & target[0];
`else
    assign step    = XLEN'(4);
    assign mis     = taken & target[1];
`endif
    assign fall_through = pc_p0 + step;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.done       <= 1'b0;
            bus.pc_j_valid <= 1'b0;
            bus.misaligned <= 1'b0;
            bus.link_valid <= 1'b0;
            bus.timeout    <= 1'b0;
            bus.next_pc    <= '0;
            bus.link_value <= '0;
        end else begin
            bus.done       <= 1'b0;
            bus.pc_j_valid <= 1'b0;
            bus.misaligned <= 1'b0;
            bus.link_valid <= 1'b0;
            bus.timeout    <= tmo;
            if (state == S_RESOLVE) begin
                bus.done       <= 1'b1;
                bus.pc_j_valid <= taken & ~mis;
                bus.misaligned <= mis;
                bus.link_valid <= is_jump & ~mis;
                bus.next_pc    <= taken ? target : fall_through;
                if (is_jump) begin
                    bus.link_value <= fall_through;
                end
            end
        end
    end

endmodule
